pfft_udiv_78ns_6ns_seq: RTL and testbench
=========================================

Name: pfft_udiv_78ns_6ns_seq

Overview:
- Iterative unsigned restoring divider: 78-bit dividend by 6-bit divisor, producing quotient and remainder.
- Inverse of the 73x6 -> 78 unsigned product path in the posit FFT datapath. Used to recover mantissa or scale terms, and as a round-trip checker for that multiplier.
- Retires one quotient bit per cycle.
- Valid/ready handshake on both input and output, so upstream and downstream stages can stall freely.

Parameters:
- DIVIDEND_WIDTH, 78, dividend and quotient width.
- DIVISOR_WIDTH, 6, divisor and remainder width.
- CNT_WIDTH, 7, iteration counter width; must satisfy 2^CNT_WIDTH > DIVIDEND_WIDTH.

Ports:
- ap_clk  in  1  single clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_WIDTH  unsigned dividend.
- divisor  in  DIVISOR_WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DIVIDEND_WIDTH  unsigned quotient.
- remainder  out  DIVISOR_WIDTH  unsigned remainder.
- div_by_zero  out  1  result was produced with divisor==0.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; in_ready=0 during reset, 1 in IDLE thereafter.
  - out_valid=0; quotient=0, remainder=0, div_by_zero=0; counter=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch dividend into shift register Q and divisor into D; clear partial remainder R (DIVISOR_WIDTH+1 bits).
    - divisor==0 -> DONE.
    - Otherwise -> BUSY with counter=DIVIDEND_WIDTH-1.
  - BUSY: in_ready=0. Each cycle:
    - {R,Q} <<= 1; trial T = R - {1'b0,D}.
    - If T non-negative: R=T and Q[0]=1; else Q[0]=0.
    - When counter==0 -> DONE; else decrement the counter.
  - DONE: out_valid=1; in_ready=0. quotient=Q, remainder=R[DIVISOR_WIDTH-1:0].
    - On out_valid&out_ready -> IDLE; out_valid deasserts the next cycle.
- Latency:
  - Accept edge at cycle 0 -> out_valid high from cycle DIVIDEND_WIDTH+1 (79).
  - Divide-by-zero: out_valid high from cycle 1.
  - Throughput: one operation per 80 cycles minimum (accept + 78 iterations + handoff).
- Divide-by-zero: quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_by_zero=1. div_by_zero=0 for all other results.
- Backpressure: while out_valid & !out_ready, quotient/remainder/div_by_zero are held bit-stable and no new operands are accepted.
- in_valid in BUSY/DONE is ignored; operand ports are sampled only on the accept edge, so changes afterward have no effect.
- No simultaneous accept and retire: in_ready is low in DONE, so a new operation starts at the earliest one cycle after retire.
- Output registers change only on retire/compute paths. Outputs retain the last result after returning to IDLE until the next DONE.
- Reset mid-operation (BUSY or DONE) aborts immediately. No result is emitted and all outputs return to reset values.
- Arithmetic is pure unsigned; the remainder is always < divisor when divisor != 0. Invariant: quotient*divisor + remainder == dividend.

Decomposition:
- Shared package pfft_div_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Width constants DIVIDEND_WIDTH=78, DIVISOR_WIDTH=6.
  - Localparam for the divide-by-zero quotient pattern.
- One natural sub-module, pfft_udiv_step: combinational single-iteration shift/compare/subtract. Inputs R, Q msb, D; outputs next R, quotient bit.
- Top level holds the FSM, counter, registers and handshake.

Test Plan:
- 1000/7: accept at cycle 0 -> out_valid at cycle 79; quotient=142, remainder=6, div_by_zero=0.
- Dividend=2^78-1, divisor=63 -> quotient with bits set only at positions 0,6,12,…,72; remainder=0.
- Round-trip: dividend=a*b with a=73'h1_2345_6789_ABCD_EF01, b=45 -> quotient=a, remainder=0. Also 500 random (a, 1..63) pairs checked against the multiplier model.
- Divisor=0, dividend=0x3F5 -> out_valid at cycle 1; quotient all ones, remainder=0x35, div_by_zero=1. The next normal operation 9/2 -> quotient=4, remainder=1, div_by_zero=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable and in_ready=0 throughout. Toggle in_valid with changing operands during BUSY -> no effect on the result.
- Reset pulse (ap_rst_n low 2 cycles, asynchronous to clock) at iteration 40 -> out_valid=0 and outputs=0 immediately; in_ready=1 one cycle after release. No stray out_valid; the next operation 100/10 -> quotient=10, remainder=0.

Source files
------------

// File: rtl/pfft_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfft_div_pkg : shared types and constants for the 78/6 divider      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pfft_div_pkg;

  localparam int DIVIDEND_WIDTH = 78;
  localparam int DIVISOR_WIDTH  = 6;

  // Quotient reported when the divisor is zero.
  localparam logic [DIVIDEND_WIDTH-1:0] c_dbz_quotient = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pfft_udiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfft_udiv_step : one restoring-division iteration (shift, trial sub) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pfft_udiv_step #(
  parameter int DIVISOR_WIDTH = pfft_div_pkg::DIVISOR_WIDTH
) (
  input  logic [DIVISOR_WIDTH:0]   r_in,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] d,
  output logic [DIVISOR_WIDTH:0]   r_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH+1:0] w_shifted;
  logic [DIVISOR_WIDTH+1:0] w_trial;

  // One extra bit above the shifted remainder carries the borrow of the trial.
  assign w_shifted = {r_in, q_msb};
  assign w_trial   = w_shifted - {2'b00, d};
  assign q_bit     = ~w_trial[DIVISOR_WIDTH+1];
  assign r_out     = q_bit ? w_trial[DIVISOR_WIDTH:0] : w_shifted[DIVISOR_WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/pfft_udiv_78ns_6ns_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfft_udiv_78ns_6ns_seq : iterative unsigned 78/6 divider, one bit    |
// | per cycle, valid/ready on input and output.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module pfft_udiv_78ns_6ns_seq
  import pfft_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = pfft_div_pkg::DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = pfft_div_pkg::DIVISOR_WIDTH,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      r_ready_en;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [DIVIDEND_WIDTH-1:0] r_q;
  logic [DIVISOR_WIDTH-1:0]  r_d;
  logic [DIVISOR_WIDTH:0]    r_r;
  logic [DIVISOR_WIDTH:0]    w_r_next;
  logic                      w_q_bit;
  logic                      w_accept;

  pfft_udiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .r_in  (r_r),
    .q_msb (r_q[DIVIDEND_WIDTH-1]),
    .d     (r_d),
    .r_out (w_r_next),
    .q_bit (w_q_bit)
  );

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
    end
  end

  // r_ready_en keeps in_ready low while reset is held and until the first edge after release.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = r_ready_en;
        if (w_accept) w_state_next = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (r_cnt == '0) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_q   <= dividend;
      r_d   <= divisor;
      r_r   <= '0;
      r_cnt <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
      if (divisor == '0) begin
        quotient    <= DIVIDEND_WIDTH'(c_dbz_quotient);
        remainder   <= dividend[DIVISOR_WIDTH-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (r_state == BUSY) begin
      r_q <= {r_q[DIVIDEND_WIDTH-2:0], w_q_bit};
      r_r <= w_r_next;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end else begin
        // Final iteration publishes straight from the step outputs.
        quotient    <= {r_q[DIVIDEND_WIDTH-2:0], w_q_bit};
        remainder   <= w_r_next[DIVISOR_WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pfft_udiv_78ns_6ns_seq.sv
`default_nettype none
// Self-checking bench for pfft_udiv_78ns_6ns_seq: directed vectors, an
// arithmetic reference model and a per-cycle output comparator.
module tb_pfft_udiv_78ns_6ns_seq;

  logic        ap_clk    = 1'b0;
  logic        ap_rst_n  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [77:0] dividend  = '0;
  logic [5:0]  divisor   = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [77:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [77:0] q;
    logic [5:0]  r;
    logic        z;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pfft_udiv_78ns_6ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned division, with the divide-by-zero convention.
  function automatic res_t model(input logic [77:0] a, input logic [5:0] b);
    res_t        e;
    logic [77:0] rem;
    if (b == 6'd0) begin
      e.q = '1;
      e.r = a[5:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {72'd0, b};
      rem = a % {72'd0, b};
      e.r = rem[5:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Compare process: every cycle a result is presented it must match the oldest expectation.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_out_valid", 78'(out_valid), 78'd0);
      end else begin
        chk("quotient", quotient, exp_q[0].q);
        chk("remainder", 78'(remainder), 78'(exp_q[0].r));
        chk("div_by_zero", 78'(div_by_zero), 78'(exp_q[0].z));
        chk("in_ready_while_done", 78'(in_ready), 78'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Launch one operation, check its latency, and let it retire if out_ready is high.
  task automatic run_op(input logic [77:0] a, input logic [5:0] b, input bit noise);
    int n;
    int exp_lat;
    bit seen;
    exp_lat = (b == 6'd0) ? 1 : 79;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 78'(in_ready), 78'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge ap_clk);
      if (out_valid) begin
        seen = 1'b1;
        in_valid = 1'b0;
        chk("latency", 78'(c), 78'(exp_lat));
      end else begin
        chk("in_ready_while_busy", 78'(in_ready), 78'd0);
        if (noise) begin
          in_valid = 1'($urandom_range(0, 1));
          dividend = 78'({$urandom(), $urandom(), $urandom()});
          divisor  = 6'($urandom());
        end
      end
    end
    if (!seen) chk("result_timeout", 78'(out_valid), 78'd1);
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t        e;
    logic [72:0] a;
    logic [5:0]  b;
    logic [77:0] p;

    // Reset state
    #12;
    chk("rst_in_ready", 78'(in_ready), 78'd0);
    chk("rst_out_valid", 78'(out_valid), 78'd0);
    chk("rst_quotient", quotient, 78'd0);
    chk("rst_remainder", 78'(remainder), 78'd0);
    chk("rst_dbz", 78'(div_by_zero), 78'd0);
    #11 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("idle_in_ready", 78'(in_ready), 78'd1);

    // 1000 / 7
    e = model(78'd1000, 6'd7);
    chk("model_1000_7_q", e.q, 78'd142);
    chk("model_1000_7_r", 78'(e.r), 78'd6);
    run_op(78'd1000, 6'd7, 1'b0);

    // All-ones dividend by 63
    e = model('1, 6'd63);
    chk("model_ones_63_q", e.q, 78'h1_041041041041041041);
    chk("model_ones_63_r", 78'(e.r), 78'd0);
    run_op('1, 6'd63, 1'b0);

    // Round trip through the 73x6 product
    a = 73'h1_2345_6789_ABCD_EF01;
    p = {5'd0, a} * 78'd45;
    e = model(p, 6'd45);
    chk("model_roundtrip_q", e.q, 78'h1_2345_6789_ABCD_EF01);
    chk("model_roundtrip_r", 78'(e.r), 78'd0);
    run_op(p, 6'd45, 1'b0);

    // Divide by zero, then a normal op clears the flag
    e = model(78'h3F5, 6'd0);
    chk("model_dbz_r", 78'(e.r), 78'h35);
    run_op(78'h3F5, 6'd0, 1'b0);
    e = model(78'd9, 6'd2);
    chk("model_9_2_q", e.q, 78'd4);
    chk("model_9_2_r", 78'(e.r), 78'd1);
    run_op(78'd9, 6'd2, 1'b0);

    // Noise on the input port while busy must not disturb the result
    run_op(78'd123456789012345, 6'd13, 1'b1);

    // Backpressure: hold the result for 20 cycles with operand churn
    out_ready = 1'b0;
    run_op(78'h2A_BCDE_F012_3456_789A, 6'd37, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      dividend = 78'({$urandom(), $urandom(), $urandom()});
      divisor  = 6'($urandom());
      @(posedge ap_clk); #1;
      chk("bp_out_valid_held", 78'(out_valid), 78'd1);
      chk("bp_in_ready_low", 78'(in_ready), 78'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("bp_retired", 78'(out_valid), 78'd0);
    chk("bp_idle_ready", 78'(in_ready), 78'd1);
    chk("bp_queue_drained", 78'(exp_q.size()), 78'd0);

    // Reset in the middle of an operation
    dividend = 78'd1000;
    divisor  = 6'd7;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 78'(out_valid), 78'd0);
    chk("mid_rst_quotient", quotient, 78'd0);
    chk("mid_rst_remainder", 78'(remainder), 78'd0);
    chk("mid_rst_dbz", 78'(div_by_zero), 78'd0);
    chk("mid_rst_in_ready", 78'(in_ready), 78'd0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #4 ap_rst_n = 1'b1;
    #1 chk("post_rst_in_ready_before_edge", 78'(in_ready), 78'd0);
    @(posedge ap_clk); #1;
    chk("post_rst_in_ready", 78'(in_ready), 78'd1);
    repeat (90) @(posedge ap_clk);
    #1 chk("post_rst_no_result", 78'(out_valid), 78'd0);
    e = model(78'd100, 6'd10);
    chk("model_100_10_q", e.q, 78'd10);
    run_op(78'd100, 6'd10, 1'b0);

    // Random round trips against the product model
    for (int i = 0; i < 500; i++) begin
      a = 73'({$urandom(), $urandom(), $urandom()});
      b = 6'($urandom_range(1, 63));
      p = {5'd0, a} * {72'd0, b};
      run_op(p, b, 1'b0);
    end
    chk("final_queue_empty", 78'(exp_q.size()), 78'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
